// File: rtl/mac_arbiter_pkg.sv
// Shared parameters and types for the multiply-add arbiter slice.
package q2par;

   localparam int unsigned Width       = 8;
   localparam int unsigned NUM_REQ     = 4;
   localparam int unsigned MAC_LATENCY = 2;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } arb_state_t;

   typedef logic [$clog2(NUM_REQ)-1:0] tag_t;

endpackage

// File: rtl/mac_arbiter_pipe.sv
// Two-stage unsigned a*b+c datapath with a valid bit and requester tag
// carried alongside the data. No arbitration logic lives here.
module mac_pipe
   import q2par::*;
#(
   parameter int unsigned WIDTH = Width,
   parameter int unsigned TAG_W = $bits(tag_t)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in_a,
   input  logic [WIDTH-1:0]       in_b,
   input  logic [WIDTH-1:0]       in_c,
   input  logic [TAG_W-1:0]       in_tag,
   output logic [MAC_LATENCY-1:0] stage_valid,
   output logic [TAG_W-1:0]       out_tag,
   output logic [2*WIDTH-1:0]     out_data
);

   logic [2*WIDTH-1:0] prod_q;
   logic [2*WIDTH-1:0] c_q;
   logic [TAG_W-1:0]   tag_q;

   // Valid bits advance one stage per clock; reset drops everything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_valid <= '0;
      end else begin
         stage_valid <= {stage_valid[MAC_LATENCY-2:0], in_valid};
      end
   end

   // Stage 1: full-width product, zero-extended addend and tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q <= '0;
         c_q    <= '0;
         tag_q  <= '0;
      end else if (in_valid) begin
         prod_q <= (2*WIDTH)'(in_a) * (2*WIDTH)'(in_b);
         c_q    <= (2*WIDTH)'(in_c);
         tag_q  <= in_tag;
      end
   end

   // Stage 2: final sum; holds its value when no operation arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data <= '0;
         out_tag  <= '0;
      end else if (stage_valid[0]) begin
         out_data <= prod_q + c_q;
         out_tag  <= tag_q;
      end
   end

endmodule

// File: rtl/mac_arbiter.sv
// Round-robin arbiter sharing one pipelined multiply-add among NUM_REQ
// requesters, with run/drain/idle control.
// Optional per-requester transfer counters: define MAC_ARBITER_STATS_EN.
module mac_arbiter #(
   parameter int unsigned WIDTH   = q2par::Width,
   parameter int unsigned NUM_REQ = q2par::NUM_REQ
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   input  logic [NUM_REQ*WIDTH-1:0] req_c,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic [2*WIDTH-1:0]       rsp_data,
`ifdef MAC_ARBITER_STATS_EN
   output logic [NUM_REQ*16-1:0]    grant_cnt,
`endif
   output logic                     busy,
   output logic                     idle
);

   import q2par::*;

   localparam int unsigned TW = $clog2(NUM_REQ);

   arb_state_t             state, state_nxt;
   logic [TW-1:0]          rr_ptr;
   logic [TW-1:0]          idx;
   logic [TW-1:0]          gidx;
   logic                   gvalid;
   logic [NUM_REQ-1:0]     grant;
   logic                   xfer;
   logic [MAC_LATENCY-1:0] stage_valid;
   logic [TW-1:0]          rsp_tag;

   // Rotating-priority search from rr_ptr upward, wrapping; grants only in RUN.
   always_comb begin
      idx    = '0;
      gidx   = '0;
      gvalid = 1'b0;
      grant  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = TW'((32'(rr_ptr) + k) % NUM_REQ);
         if (!gvalid && req_valid[idx]) begin
            gvalid = 1'b1;
            gidx   = idx;
         end
      end
      if (state == RUN && gvalid) begin
         grant[gidx] = 1'b1;
      end
   end

   assign req_ready = grant;
   assign xfer      = |grant;

   // Pointer moves past the requester just served.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (xfer) begin
         rr_ptr <= (32'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state; DRAIN leaves once nothing sits ahead of the last stage,
   // so the pipe is empty right after this edge.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (en) state_nxt = RUN;
         RUN:     if (!en) state_nxt = DRAIN;
         DRAIN: begin
            if (en) begin
               state_nxt = RUN;
            end else if (~|stage_valid[MAC_LATENCY-2:0]) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   mac_pipe #(
      .WIDTH (WIDTH),
      .TAG_W (TW)
   ) u_pipe (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (xfer),
      .in_a        (req_a[gidx*WIDTH +: WIDTH]),
      .in_b        (req_b[gidx*WIDTH +: WIDTH]),
      .in_c        (req_c[gidx*WIDTH +: WIDTH]),
      .in_tag      (gidx),
      .stage_valid (stage_valid),
      .out_tag     (rsp_tag),
      .out_data    (rsp_data)
   );

   // One-hot response valid from the last-stage tag.
   always_comb begin
      rsp_valid = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         rsp_valid[i] = stage_valid[MAC_LATENCY-1] && (rsp_tag == TW'(i));
      end
   end

   assign busy = (state == RUN) | (|stage_valid);
   assign idle = (state == IDLE) & ~busy;

`ifdef MAC_ARBITER_STATS_EN
   // Saturating per-requester transfer counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i] && grant_cnt[i*16 +: 16] != 16'hFFFF) begin
               grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_mac_arbiter.sv
// Self-checking bench for mac_arbiter: queue-based reference model plus
// directed literal checks and a randomized phase.
`timescale 1ns/1ps
module tb_mac_arbiter;

   localparam int W  = 8;
   localparam int NR = 4;

   logic            clk = 1'b0;
   logic            rst, en;
   logic [NR-1:0]   req_valid, req_ready, rsp_valid;
   logic [NR*W-1:0] req_a, req_b, req_c;
   logic [2*W-1:0]  rsp_data;
   logic            busy, idle;
`ifdef MAC_ARBITER_STATS_EN
   logic [NR*16-1:0] grant_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mac_arbiter #(.WIDTH(W), .NUM_REQ(NR)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_c     (req_c),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
`ifdef MAC_ARBITER_STATS_EN
      .grant_cnt (grant_cnt),
`endif
      .busy      (busy),
      .idle      (idle)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int due;
      int tag;
      int data;
   } ent_t;

   ent_t q[$];

   // Evaluated mid-cycle: state 0=idle 1=run 2=drain; a transfer in cycle t
   // produces its result in cycle t+2.
   initial begin : model
      int mst, mrr, mcyc, mdata, sel, a, b, c;
      bit known, e_busy;
      logic [NR-1:0] e_rdy, e_vld;
      ent_t e;
      known = 0; mst = 0; mrr = 0; mcyc = 0; mdata = 0; e_rdy = '0;
      forever begin
         @(negedge clk);
         if (known) begin
            e_rdy = '0;
            if (mst == 1) begin
               for (int k = 0; k < NR; k++) begin
                  sel = (mrr + k) % NR;
                  if (e_rdy == '0 && req_valid[sel]) e_rdy[sel] = 1'b1;
               end
            end
            e_busy = (mst == 1) || (q.size() > 0);
            e_vld = '0;
            if (q.size() > 0 && q[0].due == mcyc) begin
               e_vld[q[0].tag] = 1'b1;
               mdata = q[0].data;
               void'(q.pop_front());
            end
            chk("model req_ready", 32'(req_ready), 32'(e_rdy));
            chk("model rsp_valid", 32'(rsp_valid), 32'(e_vld));
            chk("model rsp_data", 32'(rsp_data), mdata);
            chk("model busy", 32'(busy), 32'(e_busy));
            chk("model idle", 32'(idle), 32'((mst == 0) && !e_busy));
         end
         if (rst) begin
            known = 1; mst = 0; mrr = 0; mdata = 0;
            q.delete();
         end else if (known) begin
            if (e_rdy != '0) begin
               sel = 0;
               for (int k = 0; k < NR; k++) if (e_rdy[k]) sel = k;
               a = int'(req_a[sel*W +: W]);
               b = int'(req_b[sel*W +: W]);
               c = int'(req_c[sel*W +: W]);
               e.due = mcyc + 2; e.tag = sel; e.data = a * b + c;
               q.push_back(e);
               mrr = (sel + 1) % NR;
            end
            case (mst)
               0: if (en) mst = 1;
               1: if (!en) mst = 2;
               default: if (en) mst = 1; else if (q.size() == 0) mst = 0;
            endcase
         end
         mcyc++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic nc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input int a, input int b, input int c);
      req_a[i*W +: W] = W'(a);
      req_b[i*W +: W] = W'(b);
      req_c[i*W +: W] = W'(c);
   endtask

   initial begin : stim
      logic [NR-1:0] hold;
      rst = 1'b1; en = 1'b0; req_valid = '0;
      req_a = '0; req_b = '0; req_c = '0;
      repeat (2) @(posedge clk);
      #1;
      // reset / idle
      rst = 1'b0; en = 1'b0; req_valid = 4'b1111;
      #2;
      chk("idle ready", 32'(req_ready), 0);
      chk("idle idle", 32'(idle), 1);
      chk("idle rsp_valid", 32'(rsp_valid), 0);
      chk("idle rsp_data", 32'(rsp_data), 0);
      // single issue from req 2
      nc(); en = 1'b1; req_valid = 4'b0100; set_op(2, 12, 10, 5);
      nc(); #2; chk("single ready", 32'(req_ready), 4);
      nc(); req_valid = '0;
      nc(); #2;
      chk("single rsp_valid", 32'(rsp_valid), 4);
      chk("single rsp_data", 32'(rsp_data), 125);
      nc(); #2;
      chk("single rsp_valid drop", 32'(rsp_valid), 0);
      chk("single rsp_data hold", 32'(rsp_data), 125);
      // reset mid-flight: pointer now 3
      nc(); req_valid = 4'b1111; #2; chk("pre-reset ready", 32'(req_ready), 8);
      nc(); rst = 1'b1; req_valid = '0;
      nc(); rst = 1'b0; #2;
      chk("flushed rsp_valid", 32'(rsp_valid), 0);
      chk("flushed idle", 32'(idle), 1);
      // fairness
      for (int i = 0; i < NR; i++) set_op(i, i + 1, i + 2, i);
      for (int n = 0; n < 8; n++) begin
         nc(); req_valid = 4'b1111; #2;
         chk("rr ready", 32'(req_ready), 32'(1) << (n % 4));
         if (n == 2) begin
            chk("rr rsp0 valid", 32'(rsp_valid), 1);
            chk("rr rsp0 data", 32'(rsp_data), 2);
         end
         if (n == 3) begin
            chk("rr rsp1 valid", 32'(rsp_valid), 2);
            chk("rr rsp1 data", 32'(rsp_data), 7);
         end
      end
      // max operands
      nc(); req_valid = 4'b0001; set_op(0, 255, 255, 255); #2;
      chk("max ready", 32'(req_ready), 1);
      nc(); req_valid = '0;
      nc(); #2;
      chk("max rsp_valid", 32'(rsp_valid), 1);
      chk("max rsp_data", 32'(rsp_data), 65280);
      // drain
      for (int i = 0; i < NR; i++) set_op(i, 3 + i, 7, 9 - i);
      nc(); req_valid = 4'b1111; #2; chk("drain grant k", 32'(req_ready), 2);
      nc(); en = 1'b0; #2; chk("drain grant k+1", 32'(req_ready), 4);
      nc(); req_valid = 4'b1111; #2;
      chk("drain no grant", 32'(req_ready), 0);
      chk("drain busy", 32'(busy), 1);
      nc(); #2;
      chk("drain last rsp", 32'(rsp_valid), 4);
      chk("drain not idle", 32'(idle), 0);
      nc(); #2;
      chk("drain idle", 32'(idle), 1);
      chk("drain not busy", 32'(busy), 0);
      nc(); en = 1'b1; #2; chk("idle->run no grant", 32'(req_ready), 0);
      nc(); en = 1'b0; #2; chk("run grant", 32'(req_ready), 8);
      nc(); en = 1'b1; #2; chk("drain->run no grant", 32'(req_ready), 0);
      nc(); #2; chk("rerun grant", 32'(req_ready), 1);
      // randomized traffic
      hold = '0;
      for (int n = 0; n < 1500; n++) begin
         nc();
         rst = ($urandom_range(99) == 0);
         if ($urandom_range(9) == 0) en = ~en;
         for (int i = 0; i < NR; i++) begin
            if (hold[i]) begin
               req_valid[i] = ($urandom_range(19) != 0);
            end else begin
               req_valid[i] = $urandom_range(1);
               if ($urandom_range(4) == 0)
                  set_op(i, 255, 255, 255);
               else
                  set_op(i, $urandom_range(255), $urandom_range(255), $urandom_range(255));
            end
         end
         #2;
         hold = rst ? '0 : (req_valid & ~req_ready);
      end
      nc(); req_valid = '0; en = 1'b0;
      repeat (4) nc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
